// File: rtl/mem_interface.sv
// Word-addressed RAM with a multi-cycle read/write sequencer between MAR/MDR and the MDR input mux.
// Accepts level requests in IDLE, waits RD_LAT/WR_LAT cycles, then pulses mem_done for one cycle.
module mem_interface #(
    parameter int DATA_W    = 32,
    parameter int ADDR_BITS = 9,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       MAR_in,
    input  logic [DATA_W-1:0] MDR_in,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_W-1:0]      data_q;
    logic                   oor_q;
    logic                   commit;
    logic                   req_oor;

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    assign req_oor = (MAR_in >> ADDR_BITS) != '0;

    // The array is written only on the final wait edge; an async reset drops
    // the FSM to IDLE first, so an interrupted write never lands.
    assign commit = (state == WR_WAIT) && (cnt == '0) && !oor_q;

    always_ff @(posedge clk) begin
        if (commit)
            mem[addr_q] <= data_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            oor_q    <= 1'b0;
            Mdatain  <= '0;
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (read || write) begin
                        addr_q   <= MAR_in[ADDR_BITS-1:0];
                        data_q   <= MDR_in;
                        oor_q    <= req_oor;
                        mem_busy <= 1'b1;
                    end
                    if (read) begin
                        state <= RD_WAIT;
                        cnt   <= 4'(RD_LAT - 1);
                    end else if (write) begin
                        state <= WR_WAIT;
                        cnt   <= 4'(WR_LAT - 1);
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        Mdatain  <= oor_q ? '0 : mem[addr_q];
                        mem_done <= 1'b1;
                        addr_err <= oor_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        mem_done <= 1'b1;
                        addr_err <= oor_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: directed accesses push expected completions,
// a negedge monitor pops and compares on every mem_done.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        clr, read, write;
    logic [31:0] MAR_in, MDR_in, Mdatain;
    logic        mem_busy, mem_done, addr_err;

    logic        clr_b, rd_b, wr_b;
    logic [31:0] mar_b, mdr_b, dout_b;
    logic        busy_b, done_b, err_b;
    bit          b_expect = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    mem_interface #(.DATA_W(32), .ADDR_BITS(9), .RD_LAT(2), .WR_LAT(1)) dut (
        .clk(clk), .clr(clr), .read(read), .write(write),
        .MAR_in(MAR_in), .MDR_in(MDR_in), .Mdatain(Mdatain),
        .mem_busy(mem_busy), .mem_done(mem_done), .addr_err(addr_err)
    );

    mem_interface #(.WR_LAT(3)) dut_b (
        .clk(clk), .clr(clr_b), .read(rd_b), .write(wr_b),
        .MAR_in(mar_b), .MDR_in(mdr_b), .Mdatain(dout_b),
        .mem_busy(busy_b), .mem_done(done_b), .addr_err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor_a
        exp_t e;
        if (clr) begin
            if (mem_done) begin
                check("done_not_consecutive", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    check("done_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("rdata", Mdatain, e.data);
                    check("addr_err", 32'(addr_err), 32'(e.err));
                end
            end else if (addr_err) begin
                check("err_without_done", 32'(addr_err), 32'd0);
            end
            prev_done = mem_done;
        end
    end

    always @(negedge clk) begin : monitor_b
        if (done_b)
            check("b_done_expected", 32'(b_expect), 32'd1);
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_data,
                             input logic exp_err, input int exp_lat);
        int n;
        bit seen;
        sb.push_back('{data: exp_data, err: exp_err});
        read   = rd;
        write  = wr;
        MAR_in = addr;
        MDR_in = wdata;
        @(posedge clk);
        #1;
        read   = 1'b0;
        write  = 1'b0;
        MAR_in = 32'hFFFF_FFFF;
        MDR_in = 32'h5555_5555;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_accept", 32'(mem_busy), 32'd1);
            if (mem_done) seen = 1'b1;
        end
        check("latency", 32'(n), 32'(exp_lat));
        @(negedge clk);
        check("done_one_cycle", 32'(mem_done), 32'd0);
        check("idle_not_busy", 32'(mem_busy), 32'd0);
        check("data_held", Mdatain, exp_data);
    endtask

    initial begin
        int n;
        int dn;
        int last;

        clr = 1'b0; read = 1'b1; write = 1'b0; MAR_in = 32'h200; MDR_in = '0;
        clr_b = 1'b0; rd_b = 1'b0; wr_b = 1'b0; mar_b = '0; mdr_b = '0;
        repeat (3) @(negedge clk);
        check("rst_mdatain", Mdatain, 32'd0);
        check("rst_busy", 32'(mem_busy), 32'd0);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        clr = 1'b1;
        clr_b = 1'b1;
        do_access(1, 0, 32'h200, 32'h0, 32'h0, 1, 3);

        do_access(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        do_access(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3);

        do_access(0, 1, 32'h5, 32'h12345678, 32'hDEADBEEF, 0, 2);
        do_access(1, 1, 32'h5, 32'hFFFFFFFF, 32'h12345678, 0, 3);
        do_access(1, 0, 32'h5, 32'h0, 32'h12345678, 0, 3);

        do_access(0, 1, 32'h0, 32'h0000CAFE, 32'h12345678, 0, 2);
        do_access(0, 1, 32'h200, 32'hAAAAAAAA, 32'h12345678, 1, 2);
        do_access(1, 0, 32'h0, 32'h0, 32'h0000CAFE, 0, 3);
        do_access(1, 0, 32'h200, 32'h0, 32'h0, 1, 3);

        // Write request pulsed while a read is in its wait state must be dropped.
        do_access(0, 1, 32'h20, 32'h1111, 32'h0, 0, 2);
        sb.push_back('{data: 32'h1111, err: 1'b0});
        read = 1'b1; MAR_in = 32'h20;
        @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        write = 1'b1; MDR_in = 32'h2222; MAR_in = 32'h20;
        @(negedge clk);
        write = 1'b0;
        n = 0;
        while (!mem_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_read_done", 32'(mem_done), 32'd1);
        @(negedge clk);
        do_access(1, 0, 32'h20, 32'h0, 32'h1111, 0, 3);

        // Held level read: completions every RD_LAT+2 = 4 cycles.
        repeat (3) sb.push_back('{data: 32'h1111, err: 1'b0});
        read = 1'b1; MAR_in = 32'h20;
        dn = 0;
        last = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (mem_done) begin
                dn++;
                if (dn == 1) check("held_first", 32'(i), 32'd3);
                else         check("held_gap", 32'(i - last), 32'd4);
                last = i;
            end
            if (i == 10) read = 1'b0;
        end
        check("held_count", 32'(dn), 32'd3);

        // Second instance (WR_LAT=3): establish a known word, then reset mid-write.
        b_expect = 1'b1;
        wr_b = 1'b1; mar_b = 32'h7; mdr_b = 32'h11112222;
        @(posedge clk);
        #1 wr_b = 1'b0;
        n = 0;
        while (!done_b && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b_wr_latency", 32'(n), 32'd4);
        @(negedge clk);
        b_expect = 1'b0;
        wr_b = 1'b1; mar_b = 32'h7; mdr_b = 32'h0BADF00D;
        @(posedge clk);
        #1 wr_b = 1'b0;
        @(negedge clk);
        check("b_busy_mid_write", 32'(busy_b), 32'd1);
        @(negedge clk);
        clr_b = 1'b0;
        #1;
        check("b_async_rst_busy", 32'(busy_b), 32'd0);
        check("b_async_rst_done", 32'(done_b), 32'd0);
        repeat (2) @(negedge clk);
        clr_b = 1'b1;
        repeat (6) @(negedge clk);
        b_expect = 1'b1;
        rd_b = 1'b1; mar_b = 32'h7;
        @(posedge clk);
        #1 rd_b = 1'b0;
        n = 0;
        while (!done_b && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b_rd_latency", 32'(n), 32'd3);
        check("b_prior_value", dout_b, 32'h11112222);
        check("b_rd_err", 32'(err_b), 32'd0);
        @(negedge clk);
        b_expect = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
